// File: rtl/hazard_stall_ctrl.sv
// Front-end pipeline hazard controller: load-use stalls, taken-branch flushes,
// multi-cycle long-op stalls and a saturating stall-cycle statistics counter.
module hazard_stall_ctrl #(
    parameter int BRANCH_FLUSH = 1,
    parameter int CNT_W        = 4,
    parameter int STAT_W       = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [4:0]        IFID_Rs,
    input  logic [4:0]        IFID_Rt,
    input  logic              IFID_UsesRt,
    input  logic              IDEX_MemRead,
    input  logic [4:0]        IDEX_Rt,
    input  logic              BranchTaken,
    input  logic              LongOpStart,
    input  logic [CNT_W-1:0]  LongOpCycles,
    input  logic              ClearStats,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              IFIDFlush,
    output logic              IDEXBubble,
    output logic [1:0]        State,
    output logic [STAT_W-1:0] StallCount
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LONG  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0]        FLUSH_LOAD = 2'(BRANCH_FLUSH - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0] STAT_ZERO  = {STAT_W{1'b0}};
    localparam logic [STAT_W-1:0] STAT_ONE   = {{(STAT_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0] STAT_MAX   = {STAT_W{1'b1}};

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   long_cnt_r;
    logic [CNT_W-1:0]   long_cnt_nx_s;
    logic [1:0]         flush_rem_r;
    logic [1:0]         flush_rem_nx_s;
    logic [STAT_W-1:0]  stall_cnt_r;

    logic               load_use_s;
    logic               long_req_s;
    logic               pc_write_s;
    logic               ifid_write_s;
    logic               ifid_flush_s;
    logic               idex_bubble_s;

    // Hazard detection on the current ID/EX operands
    always_comb begin
        load_use_s = IDEX_MemRead & (IDEX_Rt != 5'd0) &
                     ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt)));
        long_req_s = LongOpStart & (LongOpCycles != CNT_ZERO);
    end

    // Next-state and raw pipeline control decode
    always_comb begin
        pc_write_s     = 1'b1;
        ifid_write_s   = 1'b1;
        ifid_flush_s   = 1'b0;
        idex_bubble_s  = 1'b0;
        state_nx_s     = state_r;
        long_cnt_nx_s  = long_cnt_r;
        flush_rem_nx_s = flush_rem_r;

        case (state_r)
            ST_RUN: begin
                // A load-use stall masks the branch: ID re-resolves it next cycle.
                if (load_use_s) begin
                    pc_write_s     = 1'b0;
                    ifid_write_s   = 1'b0;
                    idex_bubble_s  = 1'b1;
                    flush_rem_nx_s = 2'd0;
                end else if (BranchTaken) begin
                    ifid_flush_s   = 1'b1;
                    flush_rem_nx_s = FLUSH_LOAD;
                end else begin
                    flush_rem_nx_s = 2'd0;
                end

                if (long_req_s) begin
                    state_nx_s    = ST_LONG;
                    long_cnt_nx_s = LongOpCycles;
                end else if (flush_rem_nx_s != 2'd0) begin
                    state_nx_s    = ST_FLUSH;
                end else begin
                    state_nx_s    = ST_RUN;
                end
            end

            ST_LONG: begin
                pc_write_s    = 1'b0;
                ifid_write_s  = 1'b0;
                idex_bubble_s = 1'b1;
                if (long_cnt_r == CNT_ZERO) begin
                    long_cnt_nx_s = CNT_ZERO;
                end else begin
                    long_cnt_nx_s = long_cnt_r - CNT_ONE;
                end
                // Pending branch flushes resume once the long op drains.
                if (long_cnt_r <= CNT_ONE) begin
                    if (flush_rem_r != 2'd0) begin
                        state_nx_s = ST_FLUSH;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    state_nx_s = ST_LONG;
                end
            end

            ST_FLUSH: begin
                ifid_flush_s  = 1'b1;
                idex_bubble_s = 1'b1;
                if (flush_rem_r == 2'd0) begin
                    flush_rem_nx_s = 2'd0;
                end else begin
                    flush_rem_nx_s = flush_rem_r - 2'd1;
                end
                if (long_req_s) begin
                    state_nx_s    = ST_LONG;
                    long_cnt_nx_s = LongOpCycles;
                end else if (flush_rem_r <= 2'd1) begin
                    state_nx_s    = ST_RUN;
                end else begin
                    state_nx_s    = ST_FLUSH;
                end
            end

            default: begin
                state_nx_s     = ST_RUN;
                long_cnt_nx_s  = CNT_ZERO;
                flush_rem_nx_s = 2'd0;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r     <= ST_RUN;
            long_cnt_r  <= CNT_ZERO;
            flush_rem_r <= 2'd0;
        end else begin
            state_r     <= state_nx_s;
            long_cnt_r  <= long_cnt_nx_s;
            flush_rem_r <= flush_rem_nx_s;
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_cnt_r <= STAT_ZERO;
        end else if (ClearStats) begin
            stall_cnt_r <= STAT_ZERO;
        end else if (!pc_write_s && (stall_cnt_r != STAT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + STAT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Pipeline controls, held in the safe stall/bubble pattern while reset is low
    always_comb begin
        if (!Reset) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b0;
            IDEXBubble = 1'b1;
        end else begin
            PCWrite    = pc_write_s;
            IFIDWrite  = ifid_write_s;
            IFIDFlush  = ifid_flush_s;
            IDEXBubble = idex_bubble_s;
        end
    end

    assign State      = state_r;
    assign StallCount = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: two instances (BRANCH_FLUSH=2/STAT_W=16
// and BRANCH_FLUSH=3/STAT_W=4) driven in parallel and compared to a cycle model.
module tb_hazard_stall_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  IFID_Rs, IFID_Rt, IDEX_Rt;
    logic        IFID_UsesRt, IDEX_MemRead, BranchTaken, LongOpStart, ClearStats;
    logic [3:0]  LongOpCycles;

    logic        a_pcw, a_ifw, a_fl, a_bub;
    logic [1:0]  a_st;
    logic [15:0] a_cnt;
    logic        b_pcw, b_ifw, b_fl, b_bub;
    logic [1:0]  b_st;
    logic [3:0]  b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int m_long [2];
    int m_flush[2];
    int m_cnt  [2];
    int nx_long [2];
    int nx_flush[2];
    int nx_cnt  [2];
    int bfv [2] = '{2, 3};
    int smax[2] = '{65535, 15};

    always #5 Clk = ~Clk;

    hazard_stall_ctrl #(.BRANCH_FLUSH(2), .CNT_W(4), .STAT_W(16)) u_dut_a (
        .Clk(Clk), .Reset(Reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_UsesRt(IFID_UsesRt), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .BranchTaken(BranchTaken), .LongOpStart(LongOpStart), .LongOpCycles(LongOpCycles),
        .ClearStats(ClearStats), .PCWrite(a_pcw), .IFIDWrite(a_ifw), .IFIDFlush(a_fl),
        .IDEXBubble(a_bub), .State(a_st), .StallCount(a_cnt)
    );

    hazard_stall_ctrl #(.BRANCH_FLUSH(3), .CNT_W(4), .STAT_W(4)) u_dut_b (
        .Clk(Clk), .Reset(Reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_UsesRt(IFID_UsesRt), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .BranchTaken(BranchTaken), .LongOpStart(LongOpStart), .LongOpCycles(LongOpCycles),
        .ClearStats(ClearStats), .PCWrite(b_pcw), .IFIDWrite(b_ifw), .IFIDFlush(b_fl),
        .IDEXBubble(b_bub), .State(b_st), .StallCount(b_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: pending long-op stall cycles and pending flush cycles, long op first.
    task automatic check_and_predict();
        int pc, ifw, fl, bub, st;
        bit lu, lreq;
        string p;
        lu   = IDEX_MemRead && (IDEX_Rt != 0) &&
               ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
        lreq = LongOpStart && (LongOpCycles != 0);
        for (int i = 0; i < 2; i++) begin
            nx_long[i]  = m_long[i];
            nx_flush[i] = m_flush[i];
            if (!Reset) begin
                m_long[i] = 0; m_flush[i] = 0; m_cnt[i] = 0;
                nx_long[i] = 0; nx_flush[i] = 0;
                pc = 0; ifw = 0; fl = 0; bub = 1; st = 0;
            end else if (m_long[i] > 0) begin
                pc = 0; ifw = 0; fl = 0; bub = 1; st = 1;
                nx_long[i] = m_long[i] - 1;
            end else if (m_flush[i] > 0) begin
                pc = 1; ifw = 1; fl = 1; bub = 1; st = 2;
                nx_flush[i] = m_flush[i] - 1;
                nx_long[i]  = lreq ? int'(LongOpCycles) : 0;
            end else begin
                pc = 1; ifw = 1; fl = 0; bub = 0; st = 0;
                nx_flush[i] = 0;
                if (lu) begin
                    pc = 0; ifw = 0; bub = 1;
                end else if (BranchTaken) begin
                    fl = 1;
                    nx_flush[i] = bfv[i] - 1;
                end
                nx_long[i] = lreq ? int'(LongOpCycles) : 0;
            end
            if (!Reset || ClearStats) nx_cnt[i] = 0;
            else if (pc == 0) nx_cnt[i] = (m_cnt[i] + 1 > smax[i]) ? smax[i] : m_cnt[i] + 1;
            else nx_cnt[i] = m_cnt[i];

            p = (i == 0) ? "a" : "b";
            check_val({p, ".PCWrite"},    (i == 0) ? 32'(a_pcw) : 32'(b_pcw), pc);
            check_val({p, ".IFIDWrite"},  (i == 0) ? 32'(a_ifw) : 32'(b_ifw), ifw);
            check_val({p, ".IFIDFlush"},  (i == 0) ? 32'(a_fl)  : 32'(b_fl),  fl);
            check_val({p, ".IDEXBubble"}, (i == 0) ? 32'(a_bub) : 32'(b_bub), bub);
            check_val({p, ".State"},      (i == 0) ? 32'(a_st)  : 32'(b_st),  st);
            check_val({p, ".StallCount"}, (i == 0) ? 32'(a_cnt) : 32'(b_cnt), m_cnt[i]);
        end
    endtask

    // Inputs are set just after a falling edge; check, then advance the model on the rising edge.
    task automatic run_cycle();
        #1;
        check_and_predict();
        @(posedge Clk);
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                m_long[i]  = nx_long[i];
                m_flush[i] = nx_flush[i];
                m_cnt[i]   = nx_cnt[i];
            end
        end
        @(negedge Clk);
    endtask

    task automatic set_idle();
        IFID_Rs = 5'd1; IFID_Rt = 5'd2; IFID_UsesRt = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0; BranchTaken = 1'b0;
        LongOpStart = 1'b0; LongOpCycles = 4'd0; ClearStats = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        for (int k = 0; k < n; k++) run_cycle();
    endtask

    task automatic long_op(input logic [3:0] cyc);
        set_idle();
        LongOpStart = 1'b1; LongOpCycles = cyc;
        run_cycle();
        set_idle();
    endtask

    initial begin
        Reset = 1'b0;
        set_idle();
        @(negedge Clk);
        run_cycle();
        run_cycle();
        Reset = 1'b1;
        idle_cycles(2);

        // load-use hit on rs, then rs=0 and masked-rt cases, then rt hit
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8; run_cycle();
        set_idle(); run_cycle();
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; run_cycle();
        set_idle();
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd9; IFID_Rt = 5'd9; IFID_Rs = 5'd3; run_cycle();
        IFID_UsesRt = 1'b1; run_cycle();
        idle_cycles(1);

        // branch flush alone, then branch masked by load-use
        BranchTaken = 1'b1; run_cycle();
        idle_cycles(4);
        BranchTaken = 1'b1; IDEX_MemRead = 1'b1; IDEX_Rt = 5'd4; IFID_Rs = 5'd4; run_cycle();
        idle_cycles(2);

        // long ops of 3 and 0 cycles
        long_op(4'd3);
        idle_cycles(4);
        long_op(4'd0);
        idle_cycles(1);

        // branch and long op in the same cycle, then long op arriving mid-flush
        BranchTaken = 1'b1; LongOpStart = 1'b1; LongOpCycles = 4'd2; run_cycle();
        idle_cycles(6);
        BranchTaken = 1'b1; run_cycle();
        set_idle(); LongOpStart = 1'b1; LongOpCycles = 4'd2; run_cycle();
        idle_cycles(6);

        // saturate the 4-bit counter, then clear during a stall
        long_op(4'd15);
        idle_cycles(15);
        long_op(4'd6);
        idle_cycles(3);
        ClearStats = 1'b1; run_cycle();
        idle_cycles(4);

        // asynchronous reset in the middle of a long op
        long_op(4'd7);
        idle_cycles(2);
        Reset = 1'b0; run_cycle();
        run_cycle();
        Reset = 1'b1;
        idle_cycles(3);

        // randomized traffic with occasional clears and resets
        for (int n = 0; n < 3000; n++) begin
            IFID_Rs      = 5'($urandom_range(0, 3));
            IFID_Rt      = 5'($urandom_range(0, 3));
            IDEX_Rt      = 5'($urandom_range(0, 3));
            IFID_UsesRt  = ($urandom_range(0, 1) == 1);
            IDEX_MemRead = ($urandom_range(0, 9) < 3);
            BranchTaken  = ($urandom_range(0, 9) < 2);
            LongOpStart  = ($urandom_range(0, 9) < 1);
            LongOpCycles = 4'($urandom_range(0, 15));
            ClearStats   = ($urandom_range(0, 99) < 2);
            Reset        = ($urandom_range(0, 199) != 0);
            run_cycle();
        end
        Reset = 1'b1;
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
